inst_fetch_buffer: RTL and testbench
====================================

# inst_fetch_buffer

Direct-mapped, one-word-per-line instruction buffer that answers the program counter's fetch address in the IF stage of the pipelined CPU. On a hit it returns the instruction combinationally in the same cycle. On a miss it drives `stall_o` back to the PC and hazard logic, fetches the word from backing instruction memory over a req/ack handshake, then releases the stall. It is the responder side of the PC's address output, and the producer of the PC's stall input.

## Interface
- `LINES`, 64: number of lines; power of two, ≥ 2.
- `ADDR_W`, 32: byte-address width.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset; synchronous, active-high.
- `req_valid_i` input 1: fetch request valid; tied to the CPU start signal.
- `pc_i` input ADDR_W: fetch byte address from the PC; bits [1:0] ignored.
- `flush_i` input 1: invalidate all lines.
- `inst_o` output 32: instruction word; valid when `req_valid_i & ~stall_o`, otherwise 0.
- `stall_o` output 1: fetch not satisfied this cycle; the PC holds.
- `mem_req_o` output 1: backing-memory read request.
- `mem_addr_o` output ADDR_W: word-aligned miss address; bits [1:0] = 0.
- `mem_ack_i` input 1: backing memory returns data this cycle.
- `mem_data_i` input 32: returned word, sampled when `mem_ack_i`.
- `miss_cnt_o` output 32: saturating miss counter.

## Operation
- Index = `pc_i[IDX+1:2]`, where IDX = log2(LINES). Tag = `pc_i[ADDR_W-1:IDX+2]`.
- Hit = `valid[idx] & tag match`.
- **IDLE**
  - `req_valid_i` and hit: `inst_o` = data[idx], `stall_o` = 0.
  - `req_valid_i` and miss: `stall_o` = 1 (combinational). Latch the word address. Increment `miss_cnt_o`, saturating at 0xFFFF_FFFF. Next state is MISS.
  - `req_valid_i` = 0: `stall_o` = 0, `inst_o` = 0, no lookup side effects.
- **MISS**
  - `stall_o` = 1 and `mem_req_o` = 1.
  - `mem_addr_o` = latched address, held stable until ack.
  - On `mem_ack_i`: write data/tag to the latched index, set valid, drop `mem_req_o`, next state is IDLE.
- The requester holds `pc_i` while `stall_o` = 1.
  - If `pc_i` changes anyway, the fill completes for the latched address.
  - IDLE then re-evaluates the new address.
- `mem_ack_i` while in IDLE is ignored.
- **Flush**
  - `flush_i` clears every valid bit in one cycle.
  - If asserted in the same cycle as a fill ack, the fill writes data/tag but valid stays 0.
  - The FSM still returns to IDLE, and the next lookup misses.
  - Flush in IDLE with a hit that cycle: the instruction is still delivered that cycle, and invalidation takes effect from the next cycle.
- **Reset**
  - Reset in any state, including mid-MISS: state to IDLE, all valid to 0, `miss_cnt_o` to 0, `mem_req_o` to 0 the next cycle.
  - Data/tag arrays are not reset.
  - An ack arriving after reset is ignored.

## Timing
- Reset values:
  - `stall_o` = 0 (IDLE with `req_valid_i` low; otherwise per lookup).
  - `mem_req_o` = 0, `mem_addr_o` = 0, `miss_cnt_o` = 0, `inst_o` = 0.
- Hit latency: 0 cycles (combinational from `pc_i`).
- Miss sequence, with miss detected in cycle t:
  - t: stall, state IDLE→MISS.
  - t+1 onward: `mem_req_o` high.
  - Ack in cycle t+k (k ≥ 1): array written at the t+k edge.
  - t+k+1: hit, `stall_o` low.
  - Minimum penalty is 2 stall cycles.
- `mem_req_o` and `mem_addr_o` are registered outputs.
- `stall_o` is combinational from state and lookup.

## Structure
- Package `fetch_pkg`:
  - state enum {IDLE, MISS}.
  - `WORD_W` = 32.
  - `INST_NOP` = 32'h0 (the `inst_o` value when not valid).
- Sub-module `ifetch_line_array`:
  - Data, tag and valid storage.
  - Asynchronous read and single synchronous write port.
  - Flush clears valid.
- Top level holds the FSM, address latch and miss counter.

## Test plan
- Cold fetch: reset; `pc_i` = 0x0, mem acks 3 cycles after req with 0x2002_0005 → `stall_o` high 4 cycles, `mem_addr_o` = 0x0. Next cycle `inst_o` = 0x2002_0005, stall low, `miss_cnt_o` = 1.
- Sequential hits: fill 0x0 to 0xC, replay the same PCs → zero stall cycles, correct words, `miss_cnt_o` unchanged at 4.
- Conflict eviction (LINES = 64): fetch 0x000 then 0x100 (same index), then 0x000 again → three misses, `miss_cnt_o` = 3.
- Flush with ack: `flush_i` and `mem_ack_i` in the same cycle for 0x40 → FSM returns to IDLE, next lookup of 0x40 misses again.
- Reset mid-miss: `rst_i` while `mem_req_o` = 1, then a late ack → `mem_req_o` = 0 after the edge, valid clear, ack ignored, `miss_cnt_o` = 0.
- Idle request: `req_valid_i` = 0 with arbitrary `pc_i` → `stall_o` = 0, `inst_o` = 0, `mem_req_o` never asserted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] INST_NOP = 32'h0;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifetch_line_array.sv
// Direct-mapped line storage: data, tag and valid bits, async read, one sync write.
module ifetch_line_array
  import fetch_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_c,
  output logic [TAG_W-1:0]  rd_tag_c,
  output logic [WORD_W-1:0] rd_data_c,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [WORD_W-1:0] wr_data_i
);

  logic [WORD_W-1:0] data_q [LINES];
  logic [WORD_W-1:0] data_d [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;

  // Fill writes one line; flush wins over the fill's valid bit.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      data_d[wr_idx_i]  = wr_data_i;
      tag_d[wr_idx_i]   = wr_tag_i;
      valid_d[wr_idx_i] = 1'b1;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Data and tag storage carry no reset; only valid bits are cleared.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  // Valid bits with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Asynchronous lookup port.
  always_comb begin
    rd_valid_c = valid_q[rd_idx_i];
    rd_tag_c   = tag_q[rd_idx_i];
    rd_data_c  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// IF-stage instruction buffer: zero-latency hits, stalls the PC while a miss is filled.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned LINES  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] inst_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned CNT_W = 32;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  lk_idx_c;
  logic [TAG_W-1:0]  lk_tag_c;
  logic              rd_valid_c;
  logic [TAG_W-1:0]  rd_tag_c;
  logic [WORD_W-1:0] rd_data_c;
  logic              hit_c;
  logic              fill_en_c;
  logic              unused_pc_lsb_c;

  // Split the fetch address into index and tag; byte offset is don't-care.
  always_comb begin
    lk_idx_c        = pc_i[IDX_W+1:2];
    lk_tag_c        = pc_i[ADDR_W-1:IDX_W+2];
    unused_pc_lsb_c = ^pc_i[1:0];
  end

  ifetch_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .rd_idx_i   (lk_idx_c),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .wr_en_i    (fill_en_c),
    .wr_idx_i   (addr_q[IDX_W+1:2]),
    .wr_tag_i   (addr_q[ADDR_W-1:IDX_W+2]),
    .wr_data_i  (mem_data_i)
  );

  // Lookup result and the PC-facing handshake.
  always_comb begin
    hit_c   = rd_valid_c && (rd_tag_c == lk_tag_c);
    stall_o = (state_q == MISS) || (req_valid_i && !hit_c);
    inst_o  = (req_valid_i && !stall_o) ? rd_data_c : INST_NOP;
  end

  // Next-state: latch miss address and count on a miss, fill on ack.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_req_d  = mem_req_q;
    miss_cnt_d = miss_cnt_q;
    fill_en_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !hit_c) begin
          state_d   = MISS;
          addr_d    = {pc_i[ADDR_W-1:2], 2'b00};
          mem_req_d = 1'b1;
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      MISS: begin
        if (mem_ack_i) begin
          fill_en_c = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, miss address, request and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_req_q  <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_req_q  <= mem_req_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = addr_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer with a line-occupancy reference model.
`timescale 1ns/1ps
module tb_inst_fetch_buffer;
  import fetch_pkg::*;

  localparam int unsigned LINES  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = $clog2(LINES);

  logic              clk = 1'b0;
  logic              rst_i, req_valid_i, flush_i, mem_ack_i;
  logic [ADDR_W-1:0] pc_i, mem_addr_o;
  logic [31:0]       inst_o, mem_data_i, miss_cnt_o;
  logic              stall_o, mem_req_o;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .pc_i(pc_i),
    .flush_i(flush_i), .inst_o(inst_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .miss_cnt_o(miss_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wa;
    logic [31:0] inst;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b1;
  int unsigned cached [int unsigned];   // line index -> word address held there
  logic [31:0] mem_img [bit [31:0]];
  int unsigned miss_model = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles and checks each delivered instruction.
  initial begin : monitor
    int   stall_run;
    exp_t e;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (rst_i || !mon_en || !req_valid_i) begin
        stall_run = 0;
      end else if (stall_o) begin
        stall_run++;
        check("inst_zero_while_stalled", inst_o, INST_NOP);
        if (mem_req_o && exp_q.size() > 0) check("mem_addr", mem_addr_o, exp_q[0].wa);
      end else begin
        check("pending_fetches", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("inst", inst_o, e.inst);
          check("stall_cycles", 32'(stall_run), 32'(e.stalls));
        end
        stall_run = 0;
      end
    end
  end

  // One fetch: update the model, present the PC, serve memory with ack k cycles after the miss.
  task automatic do_fetch(input logic [31:0] pc, input int k, input bit flush_now, input bit flush_ack);
    logic [31:0] wa;
    int unsigned idx;
    bit          hit, done;
    exp_t        e;
    int          j, fills, guard;
    wa  = {pc[31:2], 2'b00};
    idx = 32'(pc[IDX_W+1:2]);
    hit = cached.exists(idx) && (cached[idx] == wa);
    e.pc = pc; e.wa = wa; e.inst = mem_word(wa);
    e.stalls = hit ? 0 : (flush_ack ? 2 * (k + 1) : k + 1);
    if (flush_now || (!hit && flush_ack)) cached.delete();
    if (!hit) begin
      cached[idx] = wa;
      miss_model += flush_ack ? 2 : 1;
    end
    @(posedge clk); #1;
    pc_i = pc; req_valid_i = 1'b1; flush_i = flush_now; mem_ack_i = 1'b0;
    exp_q.push_back(e);
    j = 0; fills = 0; done = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        if (j == k) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(wa);
          flush_i    = flush_ack && (fills == 0);
          fills++;
          j = 0;
        end else begin
          j++;
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b0; flush_i = 1'b0; mem_data_i = $urandom();
      end
    end
    check("fetch_completed", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    cached.delete();
    miss_model = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] pc;
    rst_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    pc_i = '0; mem_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
    check("rst_inst", inst_o, 32'd0);

    // Cold fetch
    mem_img[32'h0] = 32'h2002_0005;
    do_fetch(32'h0, 3, 1'b0, 1'b0);
    check("cold_miss_cnt", miss_cnt_o, 32'd1);

    // Sequential fill then replay
    for (int a = 4; a < 16; a += 4) do_fetch(32'(a), int'($urandom_range(1, 4)), 1'b0, 1'b0);
    for (int a = 0; a < 16; a += 4) do_fetch(32'(a), 1, 1'b0, 1'b0);
    check("seq_miss_cnt", miss_cnt_o, 32'd4);

    // Conflict eviction on index 0
    do_reset();
    do_fetch(32'h000, 2, 1'b0, 1'b0);
    do_fetch(32'h100, 2, 1'b0, 1'b0);
    do_fetch(32'h000, 2, 1'b0, 1'b0);
    check("conflict_miss_cnt", miss_cnt_o, 32'd3);

    // Flush coincident with fill ack: refetch misses again
    do_fetch(32'h40, 2, 1'b0, 1'b1);
    check("flush_ack_miss_cnt", miss_cnt_o, 32'd5);

    // Flush during a hit: delivered now, misses next time
    do_fetch(32'h40, 1, 1'b1, 1'b0);
    do_fetch(32'h40, 1, 1'b0, 1'b0);
    check("flush_hit_miss_cnt", miss_cnt_o, 32'd6);

    // Reset in the middle of a miss, then a late ack
    mon_en = 1'b0;
    @(posedge clk); #1;
    pc_i = 32'h80; req_valid_i = 1'b1; flush_i = 1'b0;
    @(negedge clk);
    check("midmiss_stall", 32'(stall_o), 32'd1);
    for (int i = 0; i < 5 && !mem_req_o; i++) @(negedge clk);
    check("midmiss_req_seen", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b1; req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("midmiss_req_after_rst", 32'(mem_req_o), 32'd0);
    check("midmiss_cnt_after_rst", miss_cnt_o, 32'd0);
    check("midmiss_stall_after_rst", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack_req", 32'(mem_req_o), 32'd0);
    cached.delete();
    miss_model = 0;
    mon_en = 1'b1;
    do_fetch(32'h80, 2, 1'b0, 1'b0);
    check("after_rst_miss_cnt", miss_cnt_o, 32'd1);

    // Idle: no request, arbitrary PC including a resident line
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pc_i = (i == 0) ? 32'h80 : $urandom();
      @(negedge clk);
      check("idle_stall", 32'(stall_o), 32'd0);
      check("idle_inst", inst_o, 32'd0);
      check("idle_mem_req", 32'(mem_req_o), 32'd0);
      @(posedge clk); #1;
    end
    check("idle_miss_cnt", miss_cnt_o, 32'd1);

    // Randomized traffic with frequent index conflicts and occasional flushes
    for (int n = 0; n < 300; n++) begin
      pc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8)
         | 32'($urandom_range(0, 3));
      do_fetch(pc, int'($urandom_range(1, 4)), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) == 0));
      check("rand_miss_cnt", miss_cnt_o, miss_model);
    end

    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
